// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - four-digit multiplexed seven-segment scan controller
// Frame-synchronous value update, anti-ghost guard and leading-zero blanking.
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Value,
  input  logic        Load,
  output logic [3:0]  Num,
  output logic [3:0]  Anode,
  output logic [1:0]  DigitIdx,
  output logic        Updated
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  typedef enum logic {BLANK, SCAN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic [15:0]     r_active;
  logic [15:0]     r_pending;
  logic            r_pend;
  logic            r_upd;

  logic            w_wrap;
  logic            w_boundary;
  logic            w_apply;
  logic            w_blank;
  logic [3:0]      w_nib;

  assign w_wrap     = (r_cnt == LAST);
  assign w_boundary = w_wrap && (r_idx == 2'd3);
  assign w_apply    = w_boundary && (Load || r_pend);

  // A Load on the boundary cycle itself bypasses the pending register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= BLANK;
      r_cnt     <= '0;
      r_idx     <= 2'd0;
      r_active  <= 16'h0000;
      r_pending <= 16'h0000;
      r_pend    <= 1'b0;
      r_upd     <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_idx <= r_idx + 2'd1;
      r_upd <= w_apply;
      if (w_boundary) begin
        if (Load) r_active <= Value;
        else if (r_pend) r_active <= r_pending;
        if (w_apply) begin
          r_pend  <= 1'b0;
          r_state <= SCAN;
        end
      end else if (Load) begin
        r_pending <= Value;
        r_pend    <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nib   = r_active[{r_idx, 2'b00} +: 4];
    w_blank = 1'b0;
    if (LZ_SUPPRESS != 0) begin
      case (r_idx)
        2'd1:    w_blank = (r_active[15:4] == 12'h000);
        2'd2:    w_blank = (r_active[15:8] == 8'h00);
        2'd3:    w_blank = (r_active[15:12] == 4'h0);
        default: w_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    Anode = 4'b1111;
    Num   = 4'hF;
    if (r_state == SCAN && !w_blank) begin
      Num = w_nib;
      if (r_cnt >= GUARD_C) Anode = ~(4'b0001 << r_idx);
    end
  end

  assign DigitIdx = r_idx;
  assign Updated  = r_upd;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - randomized self-checking bench for sseg_scan_ctrl
module tb_sseg_scan_ctrl;
  localparam int DIV = 8;
  localparam int GRD = 2;
  localparam int LZ  = 1;
  localparam int FRAME = 4 * DIV;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Load = 1'b0;
  logic [15:0] Value = 16'h0000;
  logic [3:0]  Num;
  logic [3:0]  Anode;
  logic [1:0]  DigitIdx;
  logic        Updated;

  int total = 0;
  int bad = 0;

  int          m_t;
  bit          m_scan;
  logic [15:0] m_act;
  logic [15:0] m_pval;
  bit          m_pend;
  bit          m_upd;

  always #5 Clk = ~Clk;

  sseg_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD(GRD), .LZ_SUPPRESS(LZ)) dut (
    .Clk(Clk), .Reset(Reset), .Value(Value), .Load(Load),
    .Num(Num), .Anode(Anode), .DigitIdx(DigitIdx), .Updated(Updated)
  );

  task automatic model_reset();
    m_t = 0; m_scan = 0; m_act = 16'h0; m_pval = 16'h0; m_pend = 0; m_upd = 0;
  endtask

  // Advance one clock with the given inputs; the model follows the frame rules.
  task automatic tick(input bit ld, input logic [15:0] v);
    Load = ld; Value = v;
    @(posedge Clk);
    if ((m_t % FRAME) == FRAME - 1) begin
      m_upd = ld || m_pend;
      if (ld) m_act = v;
      else if (m_pend) m_act = m_pval;
      if (m_upd) begin m_scan = 1; m_pend = 0; end
    end else begin
      m_upd = 0;
      if (ld) begin m_pval = v; m_pend = 1; end
    end
    m_t++;
    #1;
    Load = 0;
  endtask

  function automatic logic [10:0] exp_vec();
    int idx, slot;
    logic [15:0] upper;
    bit lit;
    logic [3:0] an, nm;
    idx   = (m_t / DIV) % 4;
    slot  = m_t % DIV;
    upper = m_act >> (4 * idx);
    lit   = m_scan && (idx == 0 || upper != 0 || LZ == 0);
    nm    = lit ? upper[3:0] : 4'hF;
    an    = (lit && slot >= GRD) ? ~(4'b0001 << idx) : 4'b1111;
    return {an, nm, 2'(idx), m_upd};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if ({Anode, Num, DigitIdx, Updated} !== {4'b1111, 4'hF, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", {Anode, Num, DigitIdx, Updated}, {4'b1111, 4'hF, 2'd0, 1'b0});
    end
    Reset = 0;
    model_reset();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(0, 16'h0);
      total++;
      if (Anode !== 4'b1111 || Num !== 4'hF || Updated !== 1'b0 || {Anode, Num, DigitIdx, Updated} !== exp_vec()) begin
        bad++;
        $display("FAIL idle t=%0d got=%h exp=%h", m_t, {Anode, Num, DigitIdx, Updated}, exp_vec());
      end
    end
  endtask

  task automatic test_first_load();
    int ups = 0;
    while ((m_t % FRAME) != 4) tick(0, 16'h0);
    tick(1, 16'h1234);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(0, 16'h0);
      ups += Updated;
      total++;
      if ({Anode, Num, DigitIdx, Updated} !== exp_vec()) begin
        bad++;
        $display("FAIL first_load t=%0d got=%h exp=%h", m_t, {Anode, Num, DigitIdx, Updated}, exp_vec());
      end
    end
    total++;
    if (ups != 1) begin
      bad++;
      $display("FAIL first_load_pulses got=%0d exp=1", ups);
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [3] = '{16'h0045, 16'h0000, 16'h1000};
    for (int k = 0; k < 3; k++) begin
      tick(1, vals[k]);
      for (int i = 0; i < 2 * FRAME; i++) begin
        tick(0, 16'h0);
        total++;
        if ({Anode, Num, DigitIdx, Updated} !== exp_vec()) begin
          bad++;
          $display("FAIL lz v=%h t=%0d got=%h exp=%h", vals[k], m_t, {Anode, Num, DigitIdx, Updated}, exp_vec());
        end
      end
    end
  endtask

  task automatic test_last_wins();
    int ups = 0;
    while ((m_t % FRAME) != 0) tick(0, 16'h0);
    tick(0, 16'h0);
    tick(1, 16'h1111);
    repeat (5) tick(0, 16'h0);
    tick(1, 16'h2222);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(0, 16'h0);
      ups += Updated;
      total++;
      if ({Anode, Num, DigitIdx, Updated} !== exp_vec()) begin
        bad++;
        $display("FAIL last_wins t=%0d got=%h exp=%h", m_t, {Anode, Num, DigitIdx, Updated}, exp_vec());
      end
    end
    total++;
    if (ups != 1) begin
      bad++;
      $display("FAIL last_wins_pulses got=%0d exp=1", ups);
    end
  endtask

  task automatic test_boundary_load();
    int ups = 0;
    while ((m_t % FRAME) != 3) tick(0, 16'h0);
    tick(1, 16'h5555);
    while ((m_t % FRAME) != FRAME - 1) tick(0, 16'h0);
    tick(1, 16'hABCD);
    total++;
    if (Updated !== 1'b1 || {Anode, Num, DigitIdx, Updated} !== exp_vec()) begin
      bad++;
      $display("FAIL boundary_pulse got=%h exp=%h", {Anode, Num, DigitIdx, Updated}, exp_vec());
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(0, 16'h0);
      ups += Updated;
      total++;
      if ({Anode, Num, DigitIdx, Updated} !== exp_vec()) begin
        bad++;
        $display("FAIL boundary t=%0d got=%h exp=%h", m_t, {Anode, Num, DigitIdx, Updated}, exp_vec());
      end
      if (DigitIdx == 2'd3 && (m_t % DIV) == GRD) begin
        total++;
        if (Num !== 4'hA) begin
          bad++;
          $display("FAIL boundary_digit3 got=%h exp=a", Num);
        end
      end
    end
    total++;
    if (ups != 0) begin
      bad++;
      $display("FAIL boundary_stale_pending got=%0d exp=0", ups);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 800; i++) begin
      v = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}}, 8'hFF};
      tick($urandom_range(0, 11) == 0, v);
      total++;
      if ({Anode, Num, DigitIdx, Updated} !== exp_vec()) begin
        bad++;
        $display("FAIL random t=%0d got=%h exp=%h", m_t, {Anode, Num, DigitIdx, Updated}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    while ((m_t % DIV) != 3) tick(0, 16'h0);
    tick(1, 16'h9876);
    #2 Reset = 1;
    #1;
    total++;
    if ({Anode, Num, DigitIdx, Updated} !== {4'b1111, 4'hF, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_async got=%h exp=%h", {Anode, Num, DigitIdx, Updated}, {4'b1111, 4'hF, 2'd0, 1'b0});
    end
    @(posedge Clk);
    #1 Reset = 0;
    model_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(0, 16'h0);
      total++;
      if (Anode !== 4'b1111 || Updated !== 1'b0 || {Anode, Num, DigitIdx, Updated} !== exp_vec()) begin
        bad++;
        $display("FAIL reset_mid t=%0d got=%h exp=%h", m_t, {Anode, Num, DigitIdx, Updated}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_first_load();
    test_lz();
    test_last_wins();
    test_boundary_load();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot; legal values are 4 or greater.
REQ-002 The block SHALL have parameter GUARD, default 2: anode-off cycles at the start of each slot (anti-ghosting); legal range 0 to REFRESH_DIV-1.
REQ-003 The block SHALL have parameter LZ_SUPPRESS, default 1: 1 enables leading-zero blanking.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port Value, input, 16 bits: four BCD/hex nibbles; bits [3:0] are digit 0 (rightmost).
REQ-007 The block SHALL have port Load, input, 1 bit: a high level for one cycle requests that Value be displayed.
REQ-008 The block SHALL have port Num, output, 4 bits: the nibble for the active digit, fed to the downstream segment decoder; 4'hF is the blanking code.
REQ-009 The block SHALL have port Anode, output, 4 bits: active-low digit enables; at most one bit is low at a time.
REQ-010 The block SHALL have port DigitIdx, output, 2 bits: index of the current slot.
REQ-011 The block SHALL have port Updated, output, 1 bit: a one-cycle pulse when a new value becomes active.

Function
REQ-012 The slot counter SHALL count 0 to REFRESH_DIV-1 and then wrap; on wrap, DigitIdx SHALL increment modulo 4.
REQ-013 The frame boundary SHALL be the wrap edge where DigitIdx goes from 3 to 0.
REQ-014 The FSM SHALL have two states, BLANK and SCAN; BLANK holds all anodes off while the counters keep running.
REQ-015 The FSM SHALL move BLANK->SCAN at the first frame boundary at which a value is applied; SCAN SHALL be left only by Reset.
REQ-016 In SCAN, a Load on a non-boundary cycle SHALL capture Value into a pending register and set a pending flag.
REQ-017 For multiple Loads within one frame, the last captured Value SHALL win.
REQ-018 At a frame boundary, the active register SHALL take Value if Load is high that cycle; otherwise it SHALL take the pending value if the flag is set; otherwise it SHALL hold.
REQ-019 When a frame boundary applies a value, the pending flag SHALL clear at that boundary.
REQ-020 Updated SHALL go high for exactly the one cycle following a boundary that applied a value, including the BLANK->SCAN transition.
REQ-021 The active value SHALL never change mid-frame, so no frame is torn.
REQ-022 Num SHALL equal active[4*DigitIdx+3 : 4*DigitIdx], changing in the same cycle as DigitIdx.
REQ-023 A digit i in 1 to 3 SHALL be blanked when LZ_SUPPRESS=1 and active nibbles i..3 are all zero; digit 0 SHALL never be blanked.
REQ-024 For a blanked digit, in BLANK state, or while the slot counter < GUARD, Anode SHALL be 4'b1111; for a blanked digit or in BLANK state, Num SHALL be 4'hF.
REQ-025 In every other case, Anode[DigitIdx] SHALL be 0 and all other Anode bits SHALL be 1.
REQ-026 Anode, Num and Updated SHALL be glitch-free register outputs or decodes of registers only, with no path from Value or Load.

Reset
REQ-027 Reset high SHALL immediately, without waiting for Clk, force: slot counter 0, DigitIdx 0, state BLANK, active 16'h0000, pending cleared, Anode 4'b1111, Num 4'hF, Updated 0.
REQ-028 Reset asserted mid-slot or mid-frame SHALL discard any pending value; after release, the first rising edge SHALL start counting from 0.

Verification (REFRESH_DIV=8, GUARD=2, LZ_SUPPRESS=1)
REQ-029 Release Reset with no Load -> Anode stays 4'b1111, Num stays 4'hF and Updated stays 0 for at least 3 full frames (96 cycles).
REQ-030 Load 16'h1234 in BLANK at cycle 5 -> at the first boundary (cycle 32), state becomes SCAN and Updated pulses at cycle 33; digit 0 then shows Num=4, Anode=1110 for slot cycles 2-7 and Anode=1111 for slot cycles 0-1; digits 1-3 show 3, 2, 1 with Anode 1101, 1011, 0111.
REQ-031 Active 16'h0045 -> digits 3 and 2 show Anode 1111 with Num F, digit 1 shows Num 4, digit 0 shows Num 5; with active 16'h0000, only digit 0 shows Num 0; with active 16'h1000, all four digits are lit (LZ blanking does not apply to embedded zeros).
REQ-032 Load 16'h1111 then 16'h2222 in the same frame -> the display is unchanged until the boundary, then shows 2222 with exactly one Updated pulse.
REQ-033 Load 16'hABCD on a boundary cycle while 16'h5555 is pending -> ABCD becomes active at that boundary and the pending flag clears.
REQ-034 Reset pulsed for 1 cycle mid-slot while a value is pending -> outputs take their reset values in the same cycle; after release, display returns to BLANK and the pending value is never shown.
